// File: rtl/mcp4822_pkg.sv
// rtl/mcp4822_pkg.sv - shared states, frame bit positions and frame builder for the MCP4822 writer
package mcp4822_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FRAME_A,
    GAP,
    FRAME_B,
    GAP_B,
    LDAC_PULSE
  } state_t;

  localparam int AB_BIT   = 15;
  localparam int GA_BIT   = 13;
  localparam int SHDN_BIT = 12;

  // Bit 14 is a don't-care in the DAC and is always sent as 0.
  function automatic logic [15:0] build_frame(input logic ab, input logic ga,
                                              input logic shdn, input logic [11:0] data);
    logic [15:0] w;
    w           = {4'b0000, data};
    w[AB_BIT]   = ab;
    w[GA_BIT]   = ga;
    w[SHDN_BIT] = shdn;
    return w;
  endfunction

endpackage

// File: rtl/spi_mcp4822_if.sv
// rtl/spi_mcp4822_if.sv - sample-pair handshake bus; MCP4822_SHDN_EN adds per-channel shutdown
interface spi_mcp4822_if;
  logic [11:0] i_data_a;
  logic [11:0] i_data_b;
  logic        i_valid;
  logic        o_ready;
`ifdef MCP4822_SHDN_EN
  logic        i_shdn_a;
  logic        i_shdn_b;

  modport master (output i_data_a, i_data_b, i_valid, i_shdn_a, i_shdn_b, input o_ready);
  modport slave  (input i_data_a, i_data_b, i_valid, i_shdn_a, i_shdn_b, output o_ready);
`else
  modport master (output i_data_a, i_data_b, i_valid, input o_ready);
  modport slave  (input i_data_a, i_data_b, i_valid, output o_ready);
`endif
endinterface

// File: rtl/mcp4822_frame_tx.sv
// rtl/mcp4822_frame_tx.sv - one CS-framed 16-bit SPI mode 0,0 write, MSB first
module mcp4822_frame_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] word,
  input  logic        start,
  output logic        cs,
  output logic        sck,
  output logic        mosi,
  output logic        done
);
  localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);

  logic [HC_W-1:0] half_cnt;
  logic [4:0]      bit_cnt;
  logic [15:0]     shreg;

  // Asserted on the edge that raises CS, so the sequencer can count the gap from there.
  assign done = !cs && (half_cnt == HC_LAST) && (bit_cnt == 5'd16);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs       <= 1'b1;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      half_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (cs) begin
      if (start) begin
        cs       <= 1'b0;
        sck      <= 1'b0;
        mosi     <= word[15];
        shreg    <= {word[14:0], 1'b0};
        half_cnt <= '0;
        bit_cnt  <= '0;
      end
    end else if (half_cnt != HC_LAST) begin
      half_cnt <= half_cnt + 1'b1;
    end else begin
      half_cnt <= '0;
      if (bit_cnt == 5'd16) begin
        cs <= 1'b1;
      end else if (!sck) begin
        sck <= 1'b1;
      end else begin
        // The falling edge after bit 0 shifts in the zero fill, leaving MOSI low for the tail.
        sck     <= 1'b0;
        bit_cnt <= bit_cnt + 1'b1;
        mosi    <= shreg[15];
        shreg   <= {shreg[14:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_mcp4822.sv
// rtl/spi_mcp4822.sv - MCP4822 pair writer: frame A, gap, frame B, gap, LDAC strobe; MCP4822_SHDN_EN optional
module spi_mcp4822
  import mcp4822_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAIN_1X    = 1,
  parameter int CS_HIGH    = 8,
  parameter int LDAC_WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_mcp4822_if.slave bus,
  output logic         SCK,
  output logic         MOSI,
  output logic         CS,
  output logic         LDAC
);
  localparam int   CNT_MAX = (CS_HIGH > LDAC_WIDTH) ? CS_HIGH : LDAC_WIDTH;
  localparam int   CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic GA      = (GAIN_1X != 0);

  state_t           state;
  logic             ready;
  logic             start;
  logic [CNT_W-1:0] cnt;
  logic [11:0]      data_a;
  logic [11:0]      data_b;
  logic             shdn_a;
  logic             shdn_b;
  logic [15:0]      tx_word;
  logic             tx_done;

  assign bus.o_ready = ready;
  // The serializer latches the word on start, which is only issued on entry to FRAME_A or FRAME_B.
  assign tx_word = (state == FRAME_A) ? build_frame(1'b0, GA, shdn_a, data_a)
                                      : build_frame(1'b1, GA, shdn_b, data_b);

`ifdef MCP4822_SHDN_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shdn_a <= 1'b1;
      shdn_b <= 1'b1;
    end else if (state == IDLE && ready && bus.i_valid) begin
      shdn_a <= ~bus.i_shdn_a;
      shdn_b <= ~bus.i_shdn_b;
    end
  end
`else
  assign shdn_a = 1'b1;
  assign shdn_b = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ready  <= 1'b0;
      start  <= 1'b0;
      LDAC   <= 1'b1;
      cnt    <= '0;
      data_a <= '0;
      data_b <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: begin
          if (ready && bus.i_valid) begin
            data_a <= bus.i_data_a;
            data_b <= bus.i_data_b;
            ready  <= 1'b0;
            start  <= 1'b1;
            state  <= FRAME_A;
          end else begin
            ready <= 1'b1;
          end
        end
        FRAME_A: if (tx_done) begin
          cnt   <= '0;
          state <= GAP;
        end
        // The CS-rise cycle counts as gap cycle 1 and the start cycle as the last one.
        GAP: if (cnt == CNT_W'(CS_HIGH - 2)) begin
          start <= 1'b1;
          state <= FRAME_B;
        end else begin
          cnt <= cnt + 1'b1;
        end
        FRAME_B: if (tx_done) begin
          cnt   <= '0;
          state <= GAP_B;
        end
        GAP_B: if (cnt == CNT_W'(CS_HIGH - 1)) begin
          cnt   <= '0;
          LDAC  <= 1'b0;
          state <= LDAC_PULSE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        LDAC_PULSE: if (cnt == CNT_W'(LDAC_WIDTH - 1)) begin
          LDAC  <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mcp4822_frame_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .word  (tx_word),
    .start (start),
    .cs    (CS),
    .sck   (SCK),
    .mosi  (MOSI),
    .done  (tx_done)
  );

endmodule

// File: tb/tb_spi_mcp4822.sv
// tb/tb_spi_mcp4822.sv - directed bench: default, GAIN_1X=0 and CLK_DIV=2 instances; MCP4822_SHDN_EN optional
module tb_spi_mcp4822;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  spi_mcp4822_if if0 ();
  spi_mcp4822_if if1 ();
  spi_mcp4822_if if2 ();

  wire [2:0] sck_w, mosi_w, cs_w, ldac_w;
  wire [2:0] rdy_w = {if2.o_ready, if1.o_ready, if0.o_ready};

  spi_mcp4822 dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave),
                    .SCK(sck_w[0]), .MOSI(mosi_w[0]), .CS(cs_w[0]), .LDAC(ldac_w[0]));
  spi_mcp4822 #(.GAIN_1X(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave),
                    .SCK(sck_w[1]), .MOSI(mosi_w[1]), .CS(cs_w[1]), .LDAC(ldac_w[1]));
  spi_mcp4822 #(.CLK_DIV(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave),
                    .SCK(sck_w[2]), .MOSI(mosi_w[2]), .CS(cs_w[2]), .LDAC(ldac_w[2]));

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] words[2];
  int edges[2], cs_first[2], cs_last[2];
  int ldac_first, ldac_last, ready_cyc, viol, hi_min, hi_max;

  task automatic drive(input int sel, input logic v, input logic [11:0] a, input logic [11:0] b);
    case (sel)
      0: begin if0.i_valid = v; if0.i_data_a = a; if0.i_data_b = b; end
      1: begin if1.i_valid = v; if1.i_data_a = a; if1.i_data_b = b; end
      default: begin if2.i_valid = v; if2.i_data_a = a; if2.i_data_b = b; end
    endcase
  endtask

  // One handshake on instance sel, then record frames and timing until o_ready returns.
  task automatic capture_pair(input int sel, input logic [11:0] a, input logic [11:0] b);
    int cyc, fidx, to, hi_run;
    logic p_sck, p_cs, p_mosi, fin;
    for (int i = 0; i < 2; i++) begin
      words[i] = '0; edges[i] = 0; cs_first[i] = -1; cs_last[i] = -1;
    end
    ldac_first = -1; ldac_last = -1; ready_cyc = -1; viol = 0;
    hi_min = 9999; hi_max = 0; hi_run = 0; fidx = -1; to = 0; fin = 1'b0;
    @(negedge clk);
    while (!rdy_w[sel] && to < 50) begin @(negedge clk); to++; end
    drive(sel, 1'b1, a, b);
    @(negedge clk);
    drive(sel, 1'b0, 12'h000, 12'h000);
    cyc = 0;
    p_sck = sck_w[sel]; p_cs = cs_w[sel]; p_mosi = mosi_w[sel];
    while (cyc < 1000 && !fin) begin
      @(negedge clk);
      cyc++;
      if (p_cs && !cs_w[sel]) begin fidx++; if (fidx < 2) cs_first[fidx] = cyc; end
      if (!p_cs && cs_w[sel] && fidx >= 0 && fidx < 2) cs_last[fidx] = cyc - 1;
      if (!p_sck && sck_w[sel] && fidx >= 0 && fidx < 2) begin
        words[fidx] = {words[fidx][14:0], mosi_w[sel]};
        edges[fidx]++;
      end
      if (sck_w[sel]) hi_run++;
      else if (p_sck) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        hi_run = 0;
      end
      if (!ldac_w[sel] && !cs_w[sel]) viol++;
      if (cs_w[sel] && p_cs && sck_w[sel] != p_sck) viol++;
      if (cs_w[sel] && mosi_w[sel]) viol++;
      if (mosi_w[sel] != p_mosi && !(p_cs && !cs_w[sel]) && !(p_sck && !sck_w[sel])) viol++;
      if (!ldac_w[sel]) begin if (ldac_first < 0) ldac_first = cyc; ldac_last = cyc; end
      if (rdy_w[sel]) begin ready_cyc = cyc; fin = 1'b1; end
      p_sck = sck_w[sel]; p_cs = cs_w[sel]; p_mosi = mosi_w[sel];
    end
  endtask

  task automatic test_reset;
    logic [31:0] got[8], exp[8];
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got = '{cs_w, sck_w, mosi_w, ldac_w, rdy_w, 0, 0, 0};
    rst_n = 1'b1;
    @(negedge clk);
    got[5] = rdy_w; got[6] = cs_w; got[7] = ldac_w;
    exp = '{3'b111, 3'b000, 3'b000, 3'b111, 3'b000, 3'b111, 3'b111, 3'b111};
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_err++;
        $display("FAIL reset[%0d] got 0x%0h expected 0x%0h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_timing(input string nm, input int sel, input logic [11:0] a, input logic [11:0] b,
                             input logic [15:0] fa, input logic [15:0] fb, input int d, input int flen);
    logic [31:0] got[15], exp[15];
    int gb;
    capture_pair(sel, a, b);
    gb = flen + 8;
    got = '{words[0], words[1], edges[0], edges[1], cs_first[0], cs_last[0], cs_first[1], cs_last[1],
            ldac_first, ldac_last, ready_cyc, viol, hi_min, hi_max, 0};
    exp = '{fa, fb, 16, 16, 1, flen, gb + 1, gb + flen, gb + flen + 9, gb + flen + 12,
            gb + flen + 13, 0, d, d, 0};
    for (int i = 0; i < 14; i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_err++;
        $display("FAIL %s[%0d] got 0x%0h expected 0x%0h", nm, i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] pa[3], pb[3];
    logic [15:0] got[6], exp[6];
    int falls[6], rises[6];
    int k, nf, cyc;
    logic p_cs, p_sck, fin;
    pa = '{12'h111, 12'h7FF, 12'h0F0};
    pb = '{12'h222, 12'h800, 12'hF0F};
    exp = '{16'h3111, 16'hB222, 16'h37FF, 16'hB800, 16'h30F0, 16'hBF0F};
    for (int i = 0; i < 6; i++) begin got[i] = '0; falls[i] = -1; rises[i] = -1; end
    k = 0; nf = 0; cyc = 0; fin = 1'b0;
    @(negedge clk);
    p_cs = cs_w[0]; p_sck = sck_w[0];
    while (cyc < 2000 && !fin) begin
      if (k == 3) if0.i_valid = 1'b0;
      else if (rdy_w[0]) begin drive(0, 1'b1, pa[k], pb[k]); k++; end
      else drive(0, 1'b1, 12'($urandom), 12'($urandom));
      @(negedge clk);
      cyc++;
      if (p_cs && !cs_w[0] && nf < 6) begin falls[nf] = cyc; nf++; end
      if (!p_cs && cs_w[0] && nf > 0) rises[nf-1] = cyc;
      if (!p_sck && sck_w[0] && nf > 0) got[nf-1] = {got[nf-1][14:0], mosi_w[0]};
      if (k == 3 && nf == 6 && rdy_w[0]) fin = 1'b1;
      p_cs = cs_w[0]; p_sck = sck_w[0];
    end
    if0.i_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_err++;
        $display("FAIL b2b_frame[%0d] got 0x%0h expected 0x%0h", i, got[i], exp[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if (falls[2*i] - rises[2*i-1] !== 14) begin
        n_err++;
        $display("FAIL b2b_gap[%0d] got %0d expected 14", i, falls[2*i] - rises[2*i-1]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] got[8], exp[8];
    int to, bad;
    to = 0; bad = 0;
    @(negedge clk);
    while (!rdy_w[0] && to < 50) begin @(negedge clk); to++; end
    drive(0, 1'b1, 12'hABC, 12'h123);
    @(negedge clk);
    drive(0, 1'b0, 12'h000, 12'h000);
    repeat (59) @(negedge clk);
    got[0] = cs_w[0];
    rst_n = 1'b0;
    @(negedge clk);
    got[1] = cs_w[0]; got[2] = sck_w[0]; got[3] = mosi_w[0]; got[4] = ldac_w[0]; got[5] = rdy_w[0];
    repeat (2) @(negedge clk);
    got[6] = rdy_w[0];
    rst_n = 1'b1;
    @(negedge clk);
    got[7] = rdy_w[0];
    repeat (400) begin
      @(negedge clk);
      if (!ldac_w[0] || !cs_w[0]) bad++;
    end
    exp = '{0, 1, 0, 0, 1, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_err++;
        $display("FAIL rst_mid[%0d] got 0x%0h expected 0x%0h", i, got[i], exp[i]);
      end
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL rst_mid_quiet got %0d active cycles expected 0", bad);
    end
  endtask

`ifdef MCP4822_SHDN_EN
  task automatic test_shdn;
    if0.i_shdn_a = 1'b0;
    if0.i_shdn_b = 1'b1;
    capture_pair(0, 12'h2C4, 12'h555);
    if0.i_shdn_b = 1'b0;
    n_cmp++;
    if (words[0] !== 16'h32C4) begin
      n_err++;
      $display("FAIL shdn_frame_a got 0x%0h expected 0x32c4", words[0]);
    end
    n_cmp++;
    if (words[1] !== 16'hA555) begin
      n_err++;
      $display("FAIL shdn_frame_b got 0x%0h expected 0xa555", words[1]);
    end
  endtask
`endif

  initial begin
    drive(0, 1'b0, 12'h000, 12'h000);
    drive(1, 1'b0, 12'h000, 12'h000);
    drive(2, 1'b0, 12'h000, 12'h000);
`ifdef MCP4822_SHDN_EN
    if0.i_shdn_a = 1'b0; if0.i_shdn_b = 1'b0;
    if1.i_shdn_a = 1'b0; if1.i_shdn_b = 1'b0;
    if2.i_shdn_a = 1'b0; if2.i_shdn_b = 1'b0;
`endif
    test_reset();
    test_timing("default", 0, 12'hABC, 12'h123, 16'h3ABC, 16'hB123, 4, 132);
    test_timing("gain2x", 1, 12'hFFF, 12'h000, 16'h1FFF, 16'h9000, 4, 132);
    test_timing("div2", 2, 12'h5A5, 12'hA5A, 16'h35A5, 16'hBA5A, 2, 66);
    test_back_to_back();
    test_reset_mid_frame();
`ifdef MCP4822_SHDN_EN
    test_shdn();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
